decode_stage_pipe: RTL and testbench

- Registered, parametrised instruction-decode stage; successor to the combinational control unit.
- Splits a five-field instruction word, decodes the opcode into control strobes, and builds jump and branch addresses.
- Holds the result in a one-entry output register with valid/ready handshakes on both sides.
- Adds a load-use hazard interlock and a synchronous flush. Sits between fetch and execute.

---
 rtl/decode_stage_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// Registered instruction-decode stage between fetch and execute.
// Splits the instruction word into its five fields, decodes the opcode into
// control strobes, and builds jump/branch addresses. The result sits in a
// one-entry output register with valid/ready handshakes on both sides. A
// load-use interlock holds back an instruction that reads the register a
// just-leaving lw writes. Flush kills the register contents synchronously.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | normal operation, input accepted whenever the register frees
// STALL  | load-use bubble in progress, input blocked until count expires
module decode_stage_pipe #(
    parameter int FIELD_W      = 5,
    parameter int ADDR_W       = 16,
    parameter int ALU_W        = 4,
    parameter int STALL_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5*FIELD_W-1:0] instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [FIELD_W-1:0]   op_code,
    output logic [FIELD_W-1:0]   rs,
    output logic [FIELD_W-1:0]   rt,
    output logic [FIELD_W-1:0]   rd,
    output logic [FIELD_W-1:0]   funct,
    output logic                 r_type,
    output logic                 lw,
    output logic                 sw,
    output logic                 beq,
    output logic                 bne,
    output logic                 bgt,
    output logic                 slt,
    output logic                 jr,
    output logic                 jump,
    output logic                 branch,
    output logic                 illegal,
    output logic [ALU_W-1:0]     alu_op,
    output logic [ADDR_W-1:0]    j_address,
    output logic [ADDR_W-1:0]    branch_address
);

    // Counter only needs to hold STALL_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;

    logic [FIELD_W-1:0] in_op;
    logic [FIELD_W-1:0] in_rs;
    logic [FIELD_W-1:0] in_rt;
    logic [FIELD_W-1:0] in_rd;
    logic [FIELD_W-1:0] in_funct;

    logic               d_r_type;
    logic               d_lw;
    logic               d_sw;
    logic               d_beq;
    logic               d_bne;
    logic               d_bgt;
    logic               d_slt;
    logic               d_jr;
    logic               d_jump;
    logic               d_illegal;
    logic               d_rs_used;
    logic               d_rt_used;
    logic [ALU_W-1:0]   d_alu;
    logic [ADDR_W-1:0]  d_j_addr;
    logic [ADDR_W-1:0]  d_br_addr;

    logic               hazard;
    logic               capture;
    logic               xfer;

    assign {in_op, in_rs, in_rt, in_rd, in_funct} = instr;

    // Size casts zero-extend narrow address fields and keep LSBs of wide ones.
    assign d_j_addr  = ADDR_W'({in_rt, in_rd, in_funct});
    assign d_br_addr = ADDR_W'({in_rd, in_funct});

    // Opcode decode of the incoming word, including which source registers it reads.
    always_comb begin
        d_r_type  = 1'b0;
        d_lw      = 1'b0;
        d_sw      = 1'b0;
        d_beq     = 1'b0;
        d_bne     = 1'b0;
        d_bgt     = 1'b0;
        d_slt     = 1'b0;
        d_jr      = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        d_rs_used = 1'b0;
        d_rt_used = 1'b0;
        d_alu     = '0;
        case (in_op)
            FIELD_W'(0): begin
                d_r_type  = 1'b1;
                d_alu     = in_funct[ALU_W-1:0];
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(1): begin
                d_lw      = 1'b1;
                d_rs_used = 1'b1;
            end
            FIELD_W'(2): begin
                d_sw      = 1'b1;
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(3): begin
                d_beq     = 1'b1;
                d_alu     = ALU_W'(1);
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(4): begin
                d_bne     = 1'b1;
                d_alu     = ALU_W'(1);
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(5): begin
                d_bgt     = 1'b1;
                d_alu     = ALU_W'(1);
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(6): begin
                d_slt     = 1'b1;
                d_alu     = ALU_W'(2);
                d_rs_used = 1'b1;
                d_rt_used = 1'b1;
            end
            FIELD_W'(7): begin
                d_jr      = 1'b1;
                d_rs_used = 1'b1;
            end
            FIELD_W'(8): begin
                d_jump    = 1'b1;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    // Held lw writes rt; r0 is never a real dependency.
    assign hazard = out_valid & lw & (rt != '0) &
                    ((d_rs_used & (in_rs == rt)) | (d_rt_used & (in_rt == rt)));

    assign in_ready = rst_n & (state == ST_RUN) & ~flush &
                      (~out_valid | out_ready) & ~(in_valid & hazard);

    assign capture = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;

    // Output register: load on capture, clear valid on drain or flush, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            op_code        <= '0;
            rs             <= '0;
            rt             <= '0;
            rd             <= '0;
            funct          <= '0;
            r_type         <= 1'b0;
            lw             <= 1'b0;
            sw             <= 1'b0;
            beq            <= 1'b0;
            bne            <= 1'b0;
            bgt            <= 1'b0;
            slt            <= 1'b0;
            jr             <= 1'b0;
            jump           <= 1'b0;
            branch         <= 1'b0;
            illegal        <= 1'b0;
            alu_op         <= '0;
            j_address      <= '0;
            branch_address <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            op_code        <= in_op;
            rs             <= in_rs;
            rt             <= in_rt;
            rd             <= in_rd;
            funct          <= in_funct;
            r_type         <= d_r_type;
            lw             <= d_lw;
            sw             <= d_sw;
            beq            <= d_beq;
            bne            <= d_bne;
            bgt            <= d_bgt;
            slt            <= d_slt;
            jr             <= d_jr;
            jump           <= d_jump;
            branch         <= d_beq | d_bne | d_bgt;
            illegal        <= d_illegal;
            alu_op         <= d_alu;
            j_address      <= d_j_addr;
            branch_address <= d_br_addr;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Interlock FSM: the lw leaving the register already costs one empty
    // cycle, so STALL only covers the remaining STALL_CYCLES-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else if (flush) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (xfer && in_valid && hazard && (STALL_CYCLES > 1)) begin
                        state     <= ST_STALL;
                        stall_cnt <= CNT_W'(STALL_CYCLES - 1);
                    end
                end
                ST_STALL: begin
                    if (stall_cnt == CNT_W'(1)) begin
                        state     <= ST_RUN;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: two instances (one-cycle and three-cycle
// interlock) share stimulus; a cycle-level reference model built from the
// opcode table and handshake rules predicts in_ready and all outputs.
module tb_decode_stage_pipe;

    localparam int SC_A = 1;
    localparam int SC_B = 3;

    typedef struct packed {
        logic       out_valid;
        logic [4:0] op_code;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] funct;
        logic       r_type;
        logic       lw;
        logic       sw;
        logic       beq;
        logic       bne;
        logic       bgt;
        logic       slt;
        logic       jr;
        logic       jump;
        logic       branch;
        logic       illegal;
        logic [3:0] alu_op;
        logic [15:0] j_address;
        logic [15:0] branch_address;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [24:0] instr = '0;

    wire         ir_a;
    wire         ir_b;
    wire out_t   o_a;
    wire out_t   o_b;

    int   tests = 0;
    int   fails = 0;
    int   nstep = 0;
    out_t exp_o [2];
    int   blk [2];
    logic ir_seen_a;
    logic ir_seen_b;

    always #5 clk = ~clk;

    decode_stage_pipe #(.FIELD_W(5), .ADDR_W(16), .ALU_W(4), .STALL_CYCLES(SC_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(ir_a),
        .flush(flush), .out_ready(out_ready), .out_valid(o_a.out_valid),
        .op_code(o_a.op_code), .rs(o_a.rs), .rt(o_a.rt), .rd(o_a.rd), .funct(o_a.funct),
        .r_type(o_a.r_type), .lw(o_a.lw), .sw(o_a.sw), .beq(o_a.beq), .bne(o_a.bne),
        .bgt(o_a.bgt), .slt(o_a.slt), .jr(o_a.jr), .jump(o_a.jump), .branch(o_a.branch),
        .illegal(o_a.illegal), .alu_op(o_a.alu_op), .j_address(o_a.j_address),
        .branch_address(o_a.branch_address)
    );

    decode_stage_pipe #(.FIELD_W(5), .ADDR_W(16), .ALU_W(4), .STALL_CYCLES(SC_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(ir_b),
        .flush(flush), .out_ready(out_ready), .out_valid(o_b.out_valid),
        .op_code(o_b.op_code), .rs(o_b.rs), .rt(o_b.rt), .rd(o_b.rd), .funct(o_b.funct),
        .r_type(o_b.r_type), .lw(o_b.lw), .sw(o_b.sw), .beq(o_b.beq), .bne(o_b.bne),
        .bgt(o_b.bgt), .slt(o_b.slt), .jr(o_b.jr), .jump(o_b.jump), .branch(o_b.branch),
        .illegal(o_b.illegal), .alu_op(o_b.alu_op), .j_address(o_b.j_address),
        .branch_address(o_b.branch_address)
    );

    function automatic logic [24:0] mk(input int op, input int s, input int t, input int d, input int f);
        return {5'(op), 5'(s), 5'(t), 5'(d), 5'(f)};
    endfunction

    // Expected register contents for an accepted word, straight from the opcode table.
    function automatic out_t decode(input logic [24:0] w);
        out_t d;
        d = '0;
        d.out_valid = 1'b1;
        {d.op_code, d.rs, d.rt, d.rd, d.funct} = w;
        case (int'(d.op_code))
            0: begin d.r_type = 1'b1; d.alu_op = d.funct[3:0]; end
            1: d.lw = 1'b1;
            2: d.sw = 1'b1;
            3: begin d.beq = 1'b1; d.alu_op = 4'd1; end
            4: begin d.bne = 1'b1; d.alu_op = 4'd1; end
            5: begin d.bgt = 1'b1; d.alu_op = 4'd1; end
            6: begin d.slt = 1'b1; d.alu_op = 4'd2; end
            7: d.jr = 1'b1;
            8: d.jump = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        d.branch = d.beq | d.bne | d.bgt;
        d.j_address      = 16'(int'(d.rt) * 1024 + int'(d.rd) * 32 + int'(d.funct));
        d.branch_address = 16'(int'(d.rd) * 32 + int'(d.funct));
        return d;
    endfunction

    function automatic bit reads(input logic [24:0] w, input logic [4:0] r);
        int  op;
        bit  rs_used;
        bit  rt_used;
        op = int'(w[24:20]);
        rs_used = (op <= 7);
        rt_used = (op == 0) || (op >= 2 && op <= 6);
        return (rs_used && w[19:15] == r) || (rt_used && w[14:10] == r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, nstep, got, want);
        end
    endtask

    task automatic ochk(input string tag, input out_t got, input out_t want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s step %0d observed=%h expected=%h", tag, nstep, got, want);
        end
    endtask

    // One clock of stimulus: drive at negedge, check against model, advance model at posedge.
    task automatic step(input logic v, input logic [24:0] w, input logic ordy, input logic fl);
        logic hz  [2];
        logic rdy [2];
        logic xfer;
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            hz[k]  = exp_o[k].out_valid && exp_o[k].lw && exp_o[k].rt != 5'd0 && reads(w, exp_o[k].rt);
            rdy[k] = (blk[k] == 0) && !fl && (!exp_o[k].out_valid || ordy) && !(v && hz[k]);
        end
        chk("in_ready_a", 32'(ir_a), 32'(rdy[0]));
        chk("in_ready_b", 32'(ir_b), 32'(rdy[1]));
        ochk("outputs_a", o_a, exp_o[0]);
        ochk("outputs_b", o_b, exp_o[1]);
        ir_seen_a = ir_a;
        ir_seen_b = ir_b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            xfer = exp_o[k].out_valid && ordy;
            if (fl) begin
                exp_o[k].out_valid = 1'b0;
                blk[k] = 0;
            end else begin
                if (v && rdy[k]) exp_o[k] = decode(w);
                else if (xfer) exp_o[k].out_valid = 1'b0;
                if (blk[k] > 0) blk[k]--;
                else if (xfer && v && hz[k]) blk[k] = ((k == 0) ? SC_A : SC_B) - 1;
            end
        end
        @(negedge clk);
        nstep++;
    endtask

    // Assert reset from a negedge, check immediate clearing, release on the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready_a", 32'(ir_a), 32'd0);
        chk("rst_in_ready_b", 32'(ir_b), 32'd0);
        ochk("rst_outputs_a", o_a, '0);
        ochk("rst_outputs_b", o_b, '0);
        for (int k = 0; k < 2; k++) begin
            exp_o[k] = '0;
            blk[k]   = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [24:0] lw3;
    logic [24:0] dep;
    logic [24:0] rt5;
    logic [24:0] nxt;

    initial begin
        lw3 = mk(1, 2, 3, 0, 4);
        dep = mk(0, 3, 4, 5, 0);
        rt5 = mk(0, 1, 2, 3, 5);
        nxt = mk(0, 4, 5, 6, 7);
        for (int k = 0; k < 2; k++) begin
            exp_o[k] = '0;
            blk[k]   = 0;
        end
        @(negedge clk);
        do_reset();

        // lw r3 with 1-cycle latency and address construction
        step(1'b1, lw3, 1'b1, 1'b0);
        chk("lw_valid", 32'(o_a.out_valid), 32'd1);
        chk("lw_strobe", 32'(o_a.lw), 32'd1);
        chk("lw_rt", 32'(o_a.rt), 32'd3);
        chk("lw_alu", 32'(o_a.alu_op), 32'd0);
        chk("lw_baddr", 32'(o_a.branch_address), 32'h0004);
        chk("lw_jaddr", 32'(o_a.j_address), 32'h0C04);

        // load-use: one empty cycle on A, three on B
        step(1'b1, dep, 1'b1, 1'b0);
        chk("hz_block_a", 32'(ir_seen_a), 32'd0);
        chk("gap0_a", 32'(o_a.out_valid), 32'd0);
        chk("gap0_b", 32'(o_b.out_valid), 32'd0);
        step(1'b1, dep, 1'b1, 1'b0);
        chk("gap1_a", 32'(o_a.out_valid), 32'd1);
        chk("gap1_b", 32'(o_b.out_valid), 32'd0);
        step(1'b1, dep, 1'b1, 1'b0);
        chk("gap2_b", 32'(o_b.out_valid), 32'd0);
        step(1'b1, dep, 1'b1, 1'b0);
        chk("gap3_b", 32'(o_b.out_valid), 32'd1);
        chk("gap3_b_rd", 32'(o_b.rd), 32'd5);

        // lw to r0 never interlocks
        step(1'b1, mk(1, 2, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, mk(0, 0, 0, 1, 0), 1'b1, 1'b0);
        chk("r0_ready_a", 32'(ir_seen_a), 32'd1);
        chk("r0_ready_b", 32'(ir_seen_b), 32'd1);

        // back-to-back R-types, no bubbles
        for (int n = 0; n < 3; n++) begin
            step(1'b1, rt5, 1'b1, 1'b0);
            chk("stream_ready", 32'(ir_seen_a), 32'd1);
            chk("stream_valid", 32'(o_a.out_valid), 32'd1);
            chk("stream_alu", 32'(o_a.alu_op), 32'd5);
            chk("stream_rtype", 32'(o_a.r_type), 32'd1);
        end

        // hold under backpressure, then transfer and capture together
        for (int n = 0; n < 4; n++) begin
            step(1'b1, nxt, 1'b0, 1'b0);
            chk("hold_ready", 32'(ir_seen_b), 32'd0);
            chk("hold_alu", 32'(o_b.alu_op), 32'd5);
            chk("hold_rd", 32'(o_b.rd), 32'd3);
        end
        step(1'b1, nxt, 1'b1, 1'b0);
        chk("release_ready", 32'(ir_seen_b), 32'd1);
        chk("release_alu", 32'(o_b.alu_op), 32'd7);

        // reset during a hold
        step(1'b1, rt5, 1'b0, 1'b0);
        do_reset();

        // illegal opcode
        step(1'b1, mk(12, 1, 2, 3, 4), 1'b1, 1'b0);
        chk("illegal", 32'(o_a.illegal), 32'd1);
        chk("illegal_others", 32'({o_a.r_type, o_a.lw, o_a.sw, o_a.beq, o_a.bne, o_a.bgt,
                                   o_a.slt, o_a.jr, o_a.jump, o_a.branch}), 32'd0);
        chk("illegal_alu", 32'(o_a.alu_op), 32'd0);

        // flush during STALL clears the remaining stall
        step(1'b1, lw3, 1'b1, 1'b0);
        step(1'b1, dep, 1'b1, 1'b0);
        step(1'b1, dep, 1'b1, 1'b1);
        chk("flush_stall_ready", 32'(ir_seen_b), 32'd0);
        chk("flush_valid_b", 32'(o_b.out_valid), 32'd0);
        step(1'b1, dep, 1'b1, 1'b0);
        chk("post_flush_ready_b", 32'(ir_seen_b), 32'd1);
        chk("post_flush_valid_b", 32'(o_b.out_valid), 32'd1);

        // reset during a stall
        step(1'b1, lw3, 1'b1, 1'b0);
        step(1'b1, dep, 1'b1, 1'b0);
        do_reset();
        step(1'b1, dep, 1'b1, 1'b0);
        chk("post_reset_ready_b", 32'(ir_seen_b), 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            int op;
            r  = int'($urandom_range(0, 99));
            op = (r < 8) ? int'($urandom_range(9, 31)) : (r < 40) ? 1 : int'($urandom_range(0, 8));
            step(($urandom_range(0, 9) < 7),
                 mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31))),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 24) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
